// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg
// Shared types for the AXI4-Lite master sequencer: write response codes,
// sequencer FSM state encoding and the fixed AWPROT value.
package axi4_lite_pkg;

    // AXI write response codes; anything other than OKAY marks the sequence as errored
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    // Sequencer states, also exported on the debug state port
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Unprivileged, secure, data access for every write
    localparam logic [2:0] AWPROT = 3'b000;

endpackage

// File: rtl/axi4_lite_master_sequencer.sv
// axi4_lite_master_sequencer
// Walks an external table of {address, data, strobe} entries, starting at
// index 0, and issues one AXI4-Lite write per entry until the table reports
// memory_data_valid=0 for the current index.
//
// Build option: define AXI4_LITE_SEQ_ABORT_ON_ERROR_EN to end the sequence on
// the first non-OKAY write response; without it the sequence continues and
// the error flag stays set until the next start.
//
// Handshake rule (all three channels): a transfer happens on the rising clk
// edge where VALID and READY are both 1. A VALID, once raised, stays high
// with its payload unchanged until that edge and is low from the next cycle.
// AW and W complete independently; bready is offered only once both have.
module axi4_lite_master_sequencer
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ADDRESS_WIDTH-1:0]  write_count,
    output logic [ADDRESS_WIDTH-1:0]  memory_index,
    input  logic [DATA_WIDTH-1:0]     memory_data,
    input  logic [DATA_WIDTH/8-1:0]   memory_strobe,
    input  logic [ADDRESS_WIDTH-1:0]  memory_address,
    input  logic                      memory_data_valid,
    output logic [ADDRESS_WIDTH-1:0]  m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output seq_state_t                dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    seq_state_t               r_state;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;
    logic [ADDRESS_WIDTH-1:0] r_write_count;
    logic [ADDRESS_WIDTH-1:0] r_memory_index;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_WIDTH-1:0]    r_wstrb;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_bready;
    logic                     r_aw_done;
    logic                     r_w_done;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_complete;
    logic w_w_complete;
    logic w_b_hs;
    logic w_resp_err;

    // Handshake decode; a channel counts as complete if it finished earlier or finishes now
    always_comb begin
        w_aw_hs       = r_awvalid & m_axi_awready;
        w_w_hs        = r_wvalid & m_axi_wready;
        w_aw_complete = r_aw_done | w_aw_hs;
        w_w_complete  = r_w_done | w_w_hs;
        w_b_hs        = r_bready & m_axi_bvalid;
        w_resp_err    = (m_axi_bresp != OKAY);
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_write_count  <= '0;
            r_memory_index <= '0;
            r_awaddr       <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_aw_done      <= 1'b0;
            r_w_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_memory_index <= '0;
                        r_write_count  <= '0;
                        r_error        <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (memory_data_valid) begin
                        r_awaddr  <= memory_address;
                        r_wdata   <= memory_data;
                        r_wstrb   <= memory_strobe;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WRITE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                WRITE: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_complete && w_w_complete) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_bready       <= 1'b0;
                        r_write_count  <= r_write_count + ADDR_ONE;
                        r_memory_index <= r_memory_index + ADDR_ONE;
                        if (w_resp_err) begin
                            r_error <= 1'b1;
                        end
`ifdef AXI4_LITE_SEQ_ABORT_ON_ERROR_EN
                        if (w_resp_err) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= LOAD;
                        end
`else
                        r_state <= LOAD;
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output mapping
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign write_count   = r_write_count;
    assign memory_index  = r_memory_index;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = AWPROT;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_axi4_lite_master_sequencer.sv
// tb_axi4_lite_master_sequencer
// Directed bench for axi4_lite_master_sequencer. A vector table drives whole
// sequences (table size, error injection, AW stall) and lists the expected
// completion latency, write_count and error. Hand-written sequences cover
// start during WRITE, reset mid-handshake and index wrap on a narrow build.
// Expectations follow AXI4_LITE_SEQ_ABORT_ON_ERROR_EN when it is defined.
`timescale 1ns/1ps
module tb_axi4_lite_master_sequencer;
    import axi4_lite_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          busy, done, error;
    logic [AW-1:0] write_count, memory_index;
    logic [DW-1:0] memory_data;
    logic [SW-1:0] memory_strobe;
    logic [AW-1:0] memory_address;
    logic          memory_data_valid;
    logic [AW-1:0] m_axi_awaddr;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid, awready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          m_axi_bready;
    seq_state_t    dbg_state;

    // ---------------- external table model ----------------
    logic [DW-1:0] t_data [8];
    logic [AW-1:0] t_addr [8];
    logic [SW-1:0] t_strb [8];
    logic [1:0]    t_resp [8];
    int            t_n;
    logic [DW-1:0] base_data [4];

    assign memory_data       = t_data[memory_index[2:0]];
    assign memory_strobe     = t_strb[memory_index[2:0]];
    assign memory_address    = t_addr[memory_index[2:0]];
    assign memory_data_valid = (memory_index < AW'(t_n));

    axi4_lite_master_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error),
        .write_count(write_count), .memory_index(memory_index),
        .memory_data(memory_data), .memory_strobe(memory_strobe),
        .memory_address(memory_address), .memory_data_valid(memory_data_valid),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(m_axi_bready),
        .dbg_state(dbg_state)
    );

    // ---------------- narrow instance for index wrap ----------------
    logic        w2_start;
    logic        w2_busy, w2_done, w2_error;
    logic [1:0]  w2_count, w2_index, w2_awaddr;
    logic [2:0]  w2_awprot;
    logic        w2_awvalid, w2_wvalid, w2_bready;
    logic [31:0] w2_wdata;
    logic [3:0]  w2_wstrb;
    seq_state_t  w2_state;
    int          w2_wr;
    int          w2_addr3;

    axi4_lite_master_sequencer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(2)) u_wrap (
        .clk(clk), .reset(reset), .start(w2_start),
        .busy(w2_busy), .done(w2_done), .error(w2_error),
        .write_count(w2_count), .memory_index(w2_index),
        .memory_data(32'(w2_index)), .memory_strobe(4'hF),
        .memory_address(~w2_index), .memory_data_valid(w2_wr < 5),
        .m_axi_awaddr(w2_awaddr), .m_axi_awprot(w2_awprot),
        .m_axi_awvalid(w2_awvalid), .m_axi_awready(1'b1),
        .m_axi_wdata(w2_wdata), .m_axi_wstrb(w2_wstrb),
        .m_axi_wvalid(w2_wvalid), .m_axi_wready(1'b1),
        .m_axi_bresp(2'b00), .m_axi_bvalid(w2_bready), .m_axi_bready(w2_bready),
        .dbg_state(w2_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_q[$];
    logic [SW-1:0] exp_strb_q[$];

    int   b_seq, b_count, aw_high, w_high, aw_stall_left;
    bit   aw_got, w_got, b_pend;
    bit   prev_awv, prev_aw_hs, prev_wv, prev_w_hs;
    logic [AW-1:0] prev_awaddr;
    logic [DW-1:0] prev_wdata;
    logic [SW-1:0] prev_wstrb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model and protocol monitor. Everything is evaluated on the falling
    // edge: the values seen here are what the next rising edge will sample.
    initial begin
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (reset) begin
                bvalid = 1'b0; aw_got = 0; w_got = 0; b_pend = 0;
                prev_awv = 0; prev_aw_hs = 0; prev_wv = 0; prev_w_hs = 0;
                awready = 1'b1;
            end else begin
                if (prev_aw_hs) begin
                    check("awvalid_drop", 64'(m_axi_awvalid), 64'd0);
                end else if (prev_awv) begin
                    check("awvalid_hold", 64'(m_axi_awvalid), 64'd1);
                    check("awaddr_stable", 64'(m_axi_awaddr), 64'(prev_awaddr));
                end
                if (prev_w_hs) begin
                    check("wvalid_drop", 64'(m_axi_wvalid), 64'd0);
                end else if (prev_wv) begin
                    check("wvalid_hold", 64'(m_axi_wvalid), 64'd1);
                    check("wdata_stable", 64'(m_axi_wdata), 64'(prev_wdata));
                    check("wstrb_stable", 64'(m_axi_wstrb), 64'(prev_wstrb));
                end
                if (m_axi_bready) begin
                    check("bready_after_aw", 64'(m_axi_awvalid), 64'd0);
                    check("bready_after_w", 64'(m_axi_wvalid), 64'd0);
                end
                if (b_pend) begin
                    bvalid = 1'b0;
                    b_pend = 0;
                end
                if (aw_got && w_got && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = t_resp[b_seq % 8];
                    aw_got = 0;
                    w_got  = 0;
                end
                if (m_axi_awvalid && aw_stall_left > 0) begin
                    awready = 1'b0;
                    aw_stall_left--;
                end else begin
                    awready = 1'b1;
                end
                if (m_axi_awvalid) aw_high++;
                if (m_axi_wvalid) w_high++;
                prev_awv    = m_axi_awvalid;
                prev_aw_hs  = m_axi_awvalid && awready;
                prev_awaddr = m_axi_awaddr;
                prev_wv     = m_axi_wvalid;
                prev_w_hs   = m_axi_wvalid && wready;
                prev_wdata  = m_axi_wdata;
                prev_wstrb  = m_axi_wstrb;
                if (prev_aw_hs) begin
                    aw_got = 1;
                    if (exp_addr_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_aw: got addr %0h expected none", m_axi_awaddr);
                    end else begin
                        check("awaddr", 64'(m_axi_awaddr), 64'(exp_addr_q.pop_front()));
                    end
                end
                if (prev_w_hs) begin
                    w_got = 1;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_w: got data %0h expected none", m_axi_wdata);
                    end else begin
                        check("wdata", 64'(m_axi_wdata), 64'(exp_q.pop_front()));
                        check("wstrb", 64'(m_axi_wstrb), 64'(exp_strb_q.pop_front()));
                    end
                end
                if (bvalid && m_axi_bready) begin
                    b_pend = 1;
                    b_count++;
                    b_seq++;
                end
            end
        end
    end

    // Narrow-instance observer: bvalid is tied to bready, so each bready cycle is one write
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                w2_wr = 0;
                w2_addr3 = 0;
            end else begin
                if (w2_awvalid && w2_awaddr == 2'b11) w2_addr3++;
                if (w2_bready) w2_wr++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_table(input bit alt, input int n, input int err_idx, input logic [1:0] err_resp);
        for (int k = 0; k < 8; k++) begin
            if (alt) begin
                t_addr[k] = 32'h1000_0010 + 32'(4 * k);
                t_strb[k] = 4'(1 << (k % 4));
                t_data[k] = 32'hA5A5_0000 | 32'(k);
            end else begin
                t_addr[k] = 32'h4000_0000;
                t_strb[k] = 4'b1111;
                t_data[k] = base_data[k % 4];
            end
            t_resp[k] = (k == err_idx) ? err_resp : 2'b00;
        end
        t_n = n;
    endtask

    task automatic push_expected(input int count);
        for (int k = 0; k < count; k++) begin
            exp_addr_q.push_back(t_addr[k]);
            exp_q.push_back(t_data[k]);
            exp_strb_q.push_back(t_strb[k]);
        end
    endtask

    // Pulse start, optionally re-pulse it at cycle inject_at, wait for done and check results
    task automatic run_seq(input string tag, input int stall, input int inject_at,
                           input int exp_lat, input int exp_count, input bit exp_err);
        int cyc;
        int first_aw;
        bit seen;
        b_seq = 0; b_count = 0; aw_high = 0; w_high = 0;
        aw_stall_left = stall;
        push_expected(exp_count);
        @(negedge clk);
        start = 1'b1;
        cyc = 0; first_aw = -1; seen = 0;
        while (cyc < 300 && !seen) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inject_at) ? 1'b1 : 1'b0;
            if (m_axi_awvalid && first_aw < 0) first_aw = cyc;
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: got no done expected done within 300 cycles", tag);
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_first_aw"}, 64'(first_aw), 64'(exp_count > 0 ? 2 : -1));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        check({tag, "_write_count"}, 64'(write_count), 64'(exp_count));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_b_handshakes"}, 64'(b_count), 64'(exp_count));
        check({tag, "_aw_cycles"}, 64'(aw_high), 64'(exp_count + stall));
        check({tag, "_w_cycles"}, 64'(w_high), 64'(exp_count));
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check({tag, "_state_idle"}, 64'(dbg_state), 64'(IDLE));
        repeat (3) @(negedge clk);
        check({tag, "_count_hold"}, 64'(write_count), 64'(exp_count));
        check({tag, "_error_hold"}, 64'(error), 64'(exp_err));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        int         n;
        bit         alt;
        int         err_idx;
        logic [1:0] err_resp;
        int         stall;
        int         exp_lat;
        int         exp_count;
        bit         exp_error;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc;
        bit seen;
        reset = 1'b1; start = 1'b0; w2_start = 1'b0;
        aw_stall_left = 0;
        base_data[0] = 32'hFFFF_FFFF;
        base_data[1] = 32'h0000_FFFF;
        base_data[2] = 32'hFFFF_0000;
        base_data[3] = 32'h0000_0000;
        load_table(1'b0, 0, -1, 2'b00);

        vecs[0] = '{name:"basic4",  n:4, alt:1'b0, err_idx:-1, err_resp:2'b00, stall:0, exp_lat:14, exp_count:4, exp_error:1'b0};
        vecs[1] = '{name:"empty",   n:0, alt:1'b0, err_idx:-1, err_resp:2'b00, stall:0, exp_lat:2,  exp_count:0, exp_error:1'b0};
        vecs[2] = '{name:"alt3",    n:3, alt:1'b1, err_idx:-1, err_resp:2'b00, stall:0, exp_lat:11, exp_count:3, exp_error:1'b0};
`ifdef AXI4_LITE_SEQ_ABORT_ON_ERROR_EN
        vecs[3] = '{name:"slverr1", n:4, alt:1'b0, err_idx:1, err_resp:2'b10, stall:0, exp_lat:7, exp_count:2, exp_error:1'b1};
        vecs[5] = '{name:"decerr0", n:1, alt:1'b1, err_idx:0, err_resp:2'b11, stall:0, exp_lat:4, exp_count:1, exp_error:1'b1};
        vecs[6] = '{name:"exokay0", n:2, alt:1'b1, err_idx:0, err_resp:2'b01, stall:0, exp_lat:4, exp_count:1, exp_error:1'b1};
`else
        vecs[3] = '{name:"slverr1", n:4, alt:1'b0, err_idx:1, err_resp:2'b10, stall:0, exp_lat:14, exp_count:4, exp_error:1'b1};
        vecs[5] = '{name:"decerr0", n:1, alt:1'b1, err_idx:0, err_resp:2'b11, stall:0, exp_lat:5, exp_count:1, exp_error:1'b1};
        vecs[6] = '{name:"exokay0", n:2, alt:1'b1, err_idx:0, err_resp:2'b01, stall:0, exp_lat:8, exp_count:2, exp_error:1'b1};
`endif
        vecs[4] = '{name:"awstall", n:4, alt:1'b0, err_idx:-1, err_resp:2'b00, stall:3, exp_lat:17, exp_count:4, exp_error:1'b0};
        vecs[7] = '{name:"clean",   n:4, alt:1'b0, err_idx:-1, err_resp:2'b00, stall:0, exp_lat:14, exp_count:4, exp_error:1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_count", 64'(write_count), 64'd0);
        check("rst_index", 64'(memory_index), 64'd0);
        check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_bready", 64'(m_axi_bready), 64'd0);
        check("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        check("rst_wdata", 64'(m_axi_wdata), 64'd0);
        check("rst_wstrb", 64'(m_axi_wstrb), 64'd0);
        check("awprot", 64'(m_axi_awprot), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            load_table(vecs[i].alt, vecs[i].n, vecs[i].err_idx, vecs[i].err_resp);
            run_seq(vecs[i].name, vecs[i].stall, -1, vecs[i].exp_lat, vecs[i].exp_count, vecs[i].exp_error);
        end

        // start re-pulsed while the first write is stalled in WRITE
        load_table(1'b0, 4, -1, 2'b00);
        run_seq("start_in_write", 3, 3, 17, 4, 1'b0);

        // Reset while the second entry's wvalid is high, then restart from index 0
        load_table(1'b1, 4, -1, 2'b00);
        push_expected(4);
        b_seq = 0;
        aw_stall_left = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; seen = 0;
        while (cyc < 50 && !seen) begin
            @(negedge clk);
            cyc++;
            if (m_axi_wvalid && memory_index == 1) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL midreset_wait: got no wvalid on entry 1 expected it within 50 cycles");
        end
        #2 reset = 1'b1;
        #1;
        check("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("midrst_bready", 64'(m_axi_bready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(IDLE));
        check("midrst_count", 64'(write_count), 64'd0);
        check("midrst_index", 64'(memory_index), 64'd0);
        check("midrst_awaddr", 64'(m_axi_awaddr), 64'd0);
        check("midrst_wdata", 64'(m_axi_wdata), 64'd0);
        check("midrst_wstrb", 64'(m_axi_wstrb), 64'd0);
        exp_addr_q.delete();
        exp_q.delete();
        exp_strb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_seq("after_reset", 0, -1, 14, 4, 1'b0);

        // Narrow build: five writes walk the 2-bit index through 0,1,2,3,0
        @(negedge clk);
        w2_start = 1'b1;
        cyc = 0; seen = 0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            cyc++;
            w2_start = 1'b0;
            if (w2_done) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL wrap_timeout: got no done expected done within 100 cycles");
        end
        check("wrap_latency", 64'(cyc), 64'd17);
        check("wrap_writes", 64'(w2_wr), 64'd5);
        check("wrap_index", 64'(w2_index), 64'd1);
        check("wrap_count", 64'(w2_count), 64'd1);
        check("wrap_error", 64'(w2_error), 64'd0);
        check("wrap_idx0_hits", 64'(w2_addr3), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
